// File: rtl/tx_mac_pack.sv
// Ethernet TX framer: arbitrates the ARP and IP payload streams and prepends a
// 4-word MAC header (dst MAC, src MAC, ethertype) to each granted frame.
module tx_mac_pack #(
  parameter int DATA_W = 32,
  parameter int MAC_W  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MAC_W-1:0]  cfg_mac_local,
  input  logic [MAC_W-1:0]  cfg_mac_pc,
  input  logic [DATA_W-1:0] ip_data,
  input  logic              ip_vld,
  input  logic              ip_sop,
  input  logic              ip_eop,
  input  logic [1:0]        ip_mod,
  output logic              ip_rdy,
  input  logic [DATA_W-1:0] arp_data,
  input  logic              arp_vld,
  input  logic              arp_sop,
  input  logic              arp_eop,
  input  logic [1:0]        arp_mod,
  output logic              arp_rdy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_vld,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [1:0]        tx_mod,
  input  logic              tx_rdy,
  output logic              flag_drop
);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_DATA} state_t;

  localparam logic [15:0] TYPE_ARP = 16'h0806;
  localparam logic [15:0] TYPE_IP  = 16'h0800;

  state_t            state, state_nxt;
  logic [1:0]        hdr_cnt;
  logic              rr_last_arp;
  logic              sel_arp;
  logic [MAC_W-1:0]  dst_q, src_q;

  logic              load;
  logic              req_ip, req_arp, orphan_ip, orphan_arp;
  logic              grant, grant_arp;
  logic [MAC_W-1:0]  grant_dst;
  logic [15:0]       grant_type, sel_type;
  logic [DATA_W-1:0] pay_data;
  logic              pay_vld, pay_eop, pay_acc;
  logic [1:0]        pay_mod;

  // Header layout assumes 32-bit words carrying a 48-bit MAC.
  function automatic logic [DATA_W-1:0] hdr_word(input logic [1:0]       idx,
                                                 input logic [MAC_W-1:0] dst,
                                                 input logic [MAC_W-1:0] src,
                                                 input logic [15:0]      etype);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {16'h0000, dst[47:32]};
      2'd1:    w = dst[31:0];
      2'd2:    w = src[47:16];
      default: w = {src[15:0], etype};
    endcase
    return DATA_W'(w);
  endfunction

  assign load       = !tx_vld || tx_rdy;
  assign req_ip     = ip_vld && ip_sop;
  assign req_arp    = arp_vld && arp_sop;
  assign orphan_ip  = ip_vld && !ip_sop;
  assign orphan_arp = arp_vld && !arp_sop;

  // ARP with an unknown peer is broadcast; IP always goes to the peer.
  assign grant_dst  = (grant_arp && cfg_mac_pc == '0) ? '1 : cfg_mac_pc;
  assign grant_type = grant_arp ? TYPE_ARP : TYPE_IP;
  assign sel_type   = sel_arp ? TYPE_ARP : TYPE_IP;

  assign pay_data = sel_arp ? arp_data : ip_data;
  assign pay_vld  = sel_arp ? arp_vld  : ip_vld;
  assign pay_eop  = sel_arp ? arp_eop  : ip_eop;
  assign pay_mod  = sel_arp ? arp_mod  : ip_mod;
  assign pay_acc  = (state == S_DATA) && load && pay_vld;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_HEAD;
      S_HEAD:  if (load && hdr_cnt == 2'd3) state_nxt = S_DATA;
      S_DATA:  if (pay_acc && pay_eop) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ip_rdy    = 1'b0;
    arp_rdy   = 1'b0;
    flag_drop = 1'b0;
    grant     = 1'b0;
    grant_arp = 1'b0;
    case (state)
      S_IDLE: begin
        // Orphan words (no sop) are swallowed; sop requests wait for a grant.
        ip_rdy    = orphan_ip;
        arp_rdy   = orphan_arp;
        flag_drop = orphan_ip || orphan_arp;
        grant     = req_ip || req_arp;
        grant_arp = req_arp && (!req_ip || !rr_last_arp);
      end
      S_DATA: begin
        ip_rdy  = !sel_arp && load;
        arp_rdy = sel_arp && load;
      end
      default: ;
    endcase
    if (!rst_n) begin
      ip_rdy    = 1'b0;
      arp_rdy   = 1'b0;
      flag_drop = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt     <= '0;
      rr_last_arp <= 1'b0;
      sel_arp     <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      tx_data     <= '0;
      tx_vld      <= 1'b0;
      tx_sop      <= 1'b0;
      tx_eop      <= 1'b0;
      tx_mod      <= '0;
    end else begin
      if (grant) begin
        sel_arp     <= grant_arp;
        rr_last_arp <= grant_arp;
        dst_q       <= grant_dst;
        src_q       <= cfg_mac_local;
      end
      if (load) begin
        case (state)
          S_IDLE: begin
            // W0 goes out on the grant edge itself to meet the one-cycle latency.
            if (grant) begin
              tx_data <= hdr_word(2'd0, grant_dst, cfg_mac_local, grant_type);
              tx_vld  <= 1'b1;
              tx_sop  <= 1'b1;
              tx_eop  <= 1'b0;
              tx_mod  <= '0;
              hdr_cnt <= 2'd1;
            end else begin
              tx_vld  <= 1'b0;
            end
          end
          S_HEAD: begin
            tx_data <= hdr_word(hdr_cnt, dst_q, src_q, sel_type);
            tx_vld  <= 1'b1;
            tx_sop  <= (hdr_cnt == 2'd0);
            tx_eop  <= 1'b0;
            tx_mod  <= '0;
            hdr_cnt <= hdr_cnt + 2'd1;
          end
          S_DATA: begin
            if (pay_vld) begin
              tx_data <= pay_data;
              tx_vld  <= 1'b1;
              tx_sop  <= 1'b0;
              tx_eop  <= pay_eop;
              tx_mod  <= pay_eop ? pay_mod : 2'd0;
            end else begin
              tx_vld  <= 1'b0;
            end
          end
          default: tx_vld <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_mac_pack.sv
// Self-checking bench for tx_mac_pack: directed cases plus randomized frames
// checked against a frame-level scoreboard built from the header rules.
module tb_tx_mac_pack;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] cfg_mac_local, cfg_mac_pc;
  logic [31:0] ip_data, arp_data, tx_data;
  logic        ip_vld, ip_sop, ip_eop, ip_rdy;
  logic        arp_vld, arp_sop, arp_eop, arp_rdy;
  logic [1:0]  ip_mod, arp_mod, tx_mod;
  logic        tx_vld, tx_sop, tx_eop, tx_rdy, flag_drop;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode = 0;
  word_t       exp_q[$];
  logic [31:0] buf_w [2][16];
  logic [31:0] lat_exp [5];
  bit          m_last_arp;
  logic        prev_hold = 1'b0;
  logic [36:0] prev_bits;
  word_t       want;

  tx_mac_pack #(.DATA_W(32), .MAC_W(48)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_mac_local(cfg_mac_local), .cfg_mac_pc(cfg_mac_pc),
    .ip_data(ip_data), .ip_vld(ip_vld), .ip_sop(ip_sop), .ip_eop(ip_eop),
    .ip_mod(ip_mod), .ip_rdy(ip_rdy),
    .arp_data(arp_data), .arp_vld(arp_vld), .arp_sop(arp_sop), .arp_eop(arp_eop),
    .arp_mod(arp_mod), .arp_rdy(arp_rdy),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_mod(tx_mod), .tx_rdy(tx_rdy), .flag_drop(flag_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
    word_t w;
    w.data = d; w.sop = s; w.eop = e; w.mod = m;
    exp_q.push_back(w);
  endtask

  // Reference: header from the framing rules, then the payload verbatim.
  task automatic push_frame(input bit arp, input int n, input logic [1:0] mod_last,
                            input logic [47:0] pc, input logic [47:0] lm);
    logic [47:0] dst;
    logic [15:0] et;
    dst = (arp && pc == 48'h0) ? 48'hFFFF_FFFF_FFFF : pc;
    et  = arp ? 16'h0806 : 16'h0800;
    push({16'h0000, dst[47:32]}, 1'b1, 1'b0, 2'd0);
    push(dst[31:0], 1'b0, 1'b0, 2'd0);
    push(lm[47:16], 1'b0, 1'b0, 2'd0);
    push({lm[15:0], et}, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < n; i++)
      push(buf_w[arp][i], 1'b0, i == n - 1, (i == n - 1) ? mod_last : 2'd0);
    m_last_arp = arp;
  endtask

  task automatic fill(input bit arp, input int n);
    for (int i = 0; i < n; i++) buf_w[arp][i] = $urandom;
  endtask

  task automatic drive(input bit arp, input logic v, input logic s, input logic e,
                       input logic [31:0] d, input logic [1:0] m);
    if (arp) begin
      arp_vld = v; arp_sop = s; arp_eop = e; arp_data = d; arp_mod = m;
    end else begin
      ip_vld = v; ip_sop = s; ip_eop = e; ip_data = d; ip_mod = m;
    end
  endtask

  // Presents words 0..n-1 (stopping early at stop_at), each held until accepted.
  task automatic send(input bit arp, input int n, input logic [1:0] mod_last,
                      input int mid_sop, input int stop_at);
    bit acc;
    int waited;
    @(posedge clk); #1;
    for (int i = 0; i < n && i != stop_at; i++) begin
      drive(arp, 1'b1, (i == 0) || (i == mid_sop), i == n - 1, buf_w[arp][i],
            (i == n - 1) ? mod_last : 2'($urandom_range(0, 3)));
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        acc = arp ? arp_rdy : ip_rdy;
        @(posedge clk); #1;
        waited++;
      end
      chk(arp ? "arp_accept" : "ip_accept", acc, 1'b1);
    end
    drive(arp, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [47:0] rnd_mac();
    return 48'({$urandom, $urandom});
  endfunction

  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       tx_rdy = 1'b1;
        1:       tx_rdy = !tx_rdy;
        default: tx_rdy = 1'($urandom % 2);
      endcase
    end
  end

  // Scoreboard: every consumed tx word must match the next expected word,
  // and a stalled word must stay put.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        chk("tx_hold", {tx_vld, tx_data, tx_sop, tx_eop, tx_mod}, prev_bits);
      if (tx_vld && tx_rdy) begin
        chk("tx_unexpected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk("tx_word", {tx_data, tx_sop, tx_eop, tx_mod}, want);
        end
      end
      prev_hold = tx_vld && !tx_rdy;
      prev_bits = {tx_vld, tx_data, tx_sop, tx_eop, tx_mod};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          arp, win;
    int          n, ms;
    logic [1:0]  ml;
    logic [47:0] pc, lm;

    lat_exp[0] = 32'h00001c02; lat_exp[1] = 32'h03040507; lat_exp[2] = 32'h2c020304;
    lat_exp[3] = 32'h05070800; lat_exp[4] = 32'h10111213;
    rst_n = 1'b0;
    cfg_mac_local = 48'h2c0203040507;
    cfg_mac_pc    = 48'h1c0203040507;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    m_last_arp = 1'b0;

    // Reset: outputs forced low even with an orphan word pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {tx_data, tx_vld, tx_sop, tx_eop, tx_mod, ip_rdy, arp_rdy, flag_drop}, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    rst_n = 1'b1;

    // Single-word IP frame with exact latency and known header words.
    buf_w[0][0] = 32'h10111213;
    push_frame(1'b0, 1, 2'd0, cfg_mac_pc, cfg_mac_local);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h10111213, 2'd0);
    @(negedge clk);
    chk("idle_sop_no_rdy", ip_rdy, 1'b0);
    chk("idle_no_tx", tx_vld, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 5) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      @(negedge clk);
      chk("latency_word", {tx_vld, tx_sop, tx_eop, tx_mod, tx_data},
          {1'b1, k == 1, k == 5, 2'd0, lat_exp[k-1]});
      chk("latency_ip_rdy", ip_rdy, k == 4);
    end
    wait_idle(50);

    // ARP with unknown peer: broadcast dst, mod on eop only.
    cfg_mac_pc = 48'h0;
    fill(1'b1, 2);
    push_frame(1'b1, 2, 2'd3, cfg_mac_pc, cfg_mac_local);
    send(1'b1, 2, 2'd3, -1, -1);
    wait_idle(100);

    // Orphan IP word in IDLE, then both ports orphan together.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hdead0001, 2'd0);
    @(negedge clk);
    chk("orphan_ip", {ip_rdy, arp_rdy, flag_drop, tx_vld}, 4'b1010);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hdead0002, 2'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hdead0003, 2'd0);
    @(negedge clk);
    chk("orphan_both", {ip_rdy, arp_rdy, flag_drop, tx_vld}, 4'b1110);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    @(negedge clk);
    chk("orphan_end", {flag_drop, tx_vld}, 2'b00);

    // Toggling back-pressure, with a stray sop inside the payload.
    rdy_mode = 1;
    cfg_mac_pc = 48'h1c0203040507;
    fill(1'b0, 3);
    push_frame(1'b0, 3, 2'd1, cfg_mac_pc, cfg_mac_local);
    send(1'b0, 3, 2'd1, 1, -1);
    wait_idle(100);
    rdy_mode = 0;

    // Reset restores ARP-first priority; then alternate on simultaneous requests.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    m_last_arp = 1'b0;
    for (int p = 0; p < 2; p++) begin
      fill(1'b0, 2);
      fill(1'b1, 3);
      win = !m_last_arp;
      if (win) begin
        push_frame(1'b1, 3, 2'd2, cfg_mac_pc, cfg_mac_local);
        push_frame(1'b0, 2, 2'd1, cfg_mac_pc, cfg_mac_local);
      end else begin
        push_frame(1'b0, 2, 2'd1, cfg_mac_pc, cfg_mac_local);
        push_frame(1'b1, 3, 2'd2, cfg_mac_pc, cfg_mac_local);
      end
      fork
        send(1'b1, 3, 2'd2, -1, -1);
        send(1'b0, 2, 2'd1, -1, -1);
      join
      wait_idle(100);
    end

    // Reset in the middle of the payload abandons the frame.
    fill(1'b0, 4);
    push_frame(1'b0, 4, 2'd1, cfg_mac_pc, cfg_mac_local);
    send(1'b0, 4, 2'd1, -1, 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, buf_w[0][2], 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_midframe", {tx_data, tx_vld, tx_sop, tx_eop, tx_mod, ip_rdy, arp_rdy, flag_drop}, 0);
    exp_q.delete();
    m_last_arp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_orphan", {ip_rdy, flag_drop, tx_vld}, 3'b110);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    fill(1'b1, 1);
    push_frame(1'b1, 1, 2'd0, cfg_mac_pc, cfg_mac_local);
    send(1'b1, 1, 2'd0, -1, -1);
    wait_idle(100);

    // Random frames under random back-pressure; cfg changes after grant.
    rdy_mode = 2;
    for (int f = 0; f < 24; f++) begin
      arp = 1'($urandom % 2);
      n   = $urandom_range(1, 6);
      ml  = 2'($urandom_range(0, 3));
      pc  = ($urandom % 3 == 0) ? 48'h0 : rnd_mac();
      lm  = rnd_mac();
      ms  = (n > 2 && $urandom % 3 == 0) ? $urandom_range(1, n - 1) : -1;
      cfg_mac_pc = pc;
      cfg_mac_local = lm;
      fill(arp, n);
      push_frame(arp, n, ml, pc, lm);
      fork
        send(arp, n, ml, ms, -1);
        begin
          repeat (3) @(posedge clk);
          #2;
          cfg_mac_pc = rnd_mac();
          cfg_mac_local = rnd_mac();
        end
      join
      wait_idle(400);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_mac_pack.md
TX_MAC_PACK -- requirements
Module: tx_mac_pack

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream data width.
REQ-002 SHALL have parameter MAC_W, default 48, MAC address width.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cfg_mac_local  input  MAC_W  source MAC inserted in every frame.
REQ-006 SHALL have port cfg_mac_pc  input  MAC_W  peer MAC, 0 = unknown.
REQ-007 SHALL have ports ip_data/ip_vld/ip_sop/ip_eop/ip_mod  input  DATA_W/1/1/1/2  IP payload stream.
REQ-008 SHALL have port ip_rdy  output  1  IP word accepted when ip_vld && ip_rdy.
REQ-009 SHALL have ports arp_data/arp_vld/arp_sop/arp_eop/arp_mod  input  DATA_W/1/1/1/2  ARP payload stream.
REQ-010 SHALL have port arp_rdy  output  1  ARP word accepted when arp_vld && arp_rdy.
REQ-011 SHALL have ports tx_data/tx_vld/tx_sop/tx_eop/tx_mod  output  DATA_W/1/1/1/2  framed MAC stream.
REQ-012 SHALL have port tx_rdy  input  1  downstream ready; tx word consumed when tx_vld && tx_rdy.
REQ-013 SHALL have port flag_drop  output  1  one-cycle pulse on a discarded orphan word.

Function
REQ-014 SHALL use mod = count of invalid trailing bytes in eop word (0 = 4 valid), passed through unchanged; tx_mod = 0 on non-eop words.
REQ-015 SHALL run FSM IDLE -> HEAD -> DATA -> IDLE.
REQ-016 IDLE: request = port vld && sop; on request, grant one port, latch dst/src MAC and type, go to HEAD.
REQ-017 Arbitration: single request wins; both requesting -> round-robin, port not granted last wins; after reset ARP wins first.
REQ-018 Type: ARP 16'h0806, IP 16'h0800.
REQ-019 Dst MAC: IP = cfg_mac_pc; ARP = cfg_mac_pc if nonzero, else 48'hFFFF_FFFF_FFFF; value latched at grant, later cfg changes ignored for that frame.
REQ-020 HEAD emits 4 words: W0 {16'h0000, dst[47:32]}, W1 dst[31:0], W2 src[47:16], W3 {src[15:0], type}; tx_sop=1 on W0 only.
REQ-021 Header counter 0..3 SHALL advance only when tx output register loads; after W3 loads go to DATA.
REQ-022 Output register SHALL load when !tx_vld || tx_rdy; tx_* held stable otherwise.
REQ-023 DATA: granted port rdy = (!tx_vld || tx_rdy); non-granted port rdy = 0; accepted word copied to tx next cycle with tx_sop=0, tx_eop/tx_mod from input.
REQ-024 Accepted eop word -> IDLE; next grant evaluated in the following cycle (no back-to-back header overlap).
REQ-025 Latency: request seen in cycle N (tx_rdy=1) -> W0 on tx in N+1, W3 in N+4, first payload word in N+5; zero added bubbles in DATA.
REQ-026 Payload-only frame (sop&&eop single word) SHALL produce 5-word frame, eop on word 5.
REQ-027 Input sop asserted again during DATA SHALL be forwarded as ordinary data (tx_sop=0).
REQ-028 IDLE: port with vld && !sop SHALL get rdy=1, word dropped, flag_drop=1 for that cycle; both ports orphan simultaneously -> both dropped, single pulse.
REQ-029 In IDLE and HEAD, no port with vld && sop SHALL see rdy=1.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, header counter 0, round-robin to ARP-first, tx_data=0, tx_vld/tx_sop/tx_eop=0, tx_mod=0, ip_rdy/arp_rdy=0, flag_drop=0.
REQ-031 Reset mid-frame SHALL abandon the frame; no partial frame resumes after release.

Verification
REQ-032 cfg_mac_local=48'h2c0203040507, cfg_mac_pc=48'h1c0203040507, IP frame 1 word 32'h10111213 eop mod 0 -> tx 00001c02,03040507,2c020304,05070800,10111213; sop W0, eop W5, mod 0.
REQ-033 cfg_mac_pc=0, ARP frame 2 words mod 3 on last -> W0 0000ffff, W1 ffffffff, W3 05070806, tx_mod=3 on eop only.
REQ-034 IP and ARP sop asserted same cycle after reset -> ARP frame fully, then IP frame; next simultaneous pair -> ARP (IP granted last).
REQ-035 tx_rdy toggled 1/0 every cycle during header and payload -> identical word sequence, tx_* stable while tx_rdy=0, no word lost or duplicated.
REQ-036 ip_vld=1, ip_sop=0 in IDLE -> ip_rdy=1, flag_drop=1 one cycle, no tx_vld.
REQ-037 rst_n pulsed low at payload word 2 -> all outputs 0 immediately; next frame starts with clean W0 sop.
